seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 120 ++++++++++++
 tb/tb_seq_multiplier.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with optional
// two's-complement operands handled by sign-magnitude conversion around the core.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               smode_q, smode_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] raw;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    smode_d   = smode_q;
    product_d = product_q;
    sum       = acc_q + {1'b0, mcand_q};
    raw       = {acc_q[WIDTH-1:0], q_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = a;
          q_d     = b;
          smode_d = signed_mode;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
        if (smode_q) begin
          q_d     = q_q[WIDTH-1]     ? -q_q     : q_q;
          mcand_d = mcand_q[WIDTH-1] ? -mcand_q : mcand_q;
          neg_d   = q_q[WIDTH-1] ^ mcand_q[WIDTH-1];
        end else begin
          neg_d   = 1'b0;
        end
        acc_d   = '0;
        cnt_d   = CW'(WIDTH);
        state_d = S_CALC;
      end
      S_CALC: begin
        if (!q_q[0]) sum = acc_q;
        {acc_d, q_d} = {1'b0, sum, q_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        product_d = neg_q ? -raw : raw;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      smode_q   <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      smode_q   <= smode_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (WIDTH=8): hand-computed products, latency,
// hold behaviour, ignored mid-operation inputs, reset abort and back-to-back starts.
module tb_seq_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int vectors     = 0;
  int miscompares = 0;
  logic [2*W-1:0] last_product;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .product     (product),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start edge is edge 0; expects done at edge W+2 and the previous product held until then.
  task automatic run_op(input string tag, input logic sm, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [2*W-1:0] exp, input int inject_edge);
    int done_edge;
    done_edge   = -1;
    signed_mode = sm;
    a           = av;
    b           = bv;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    a           = ~av;
    b           = ~bv;
    signed_mode = ~sm;
    for (int i = 1; i <= 20; i++) begin
      if (i == inject_edge) begin
        start = 1'b1;
        a     = 8'd9;
        b     = 8'd9;
      end
      tick();
      start = 1'b0;
      if (i == 1) check({tag, "/busy_e1"}, busy, 1);
      if (i == W + 1) check({tag, "/held"}, product, last_product);
      if (done) begin
        done_edge = i;
        break;
      end
    end
    check({tag, "/latency"}, done_edge, W + 2);
    check({tag, "/product"}, product, exp);
    check({tag, "/busy_done"}, busy, 1);
    last_product = exp;
    tick();
    check({tag, "/done_pulse"}, done, 0);
    check({tag, "/busy_idle"}, busy, 0);
  endtask

  initial begin
    int ndone;
    int first_edge;
    int second_edge;
    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    last_product = '0;
    tick();
    tick();
    check("reset/product", product, 0);
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    rst = 1'b0;

    run_op("u_ffxff", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 0);
    run_op("s_80x80", 1'b1, 8'h80, 8'h80, 16'h4000, 0);
    run_op("s_fdx05", 1'b1, 8'hFD, 8'h05, 16'hFFF1, 0);
    run_op("s_7fx80", 1'b1, 8'h7F, 8'h80, 16'hC080, 0);
    run_op("u_7fx80", 1'b0, 8'h7F, 8'h80, 16'h3F80, 0);
    run_op("u_0x200", 1'b0, 8'd0,  8'd200, 16'h0000, 0);
    run_op("u_12x34", 1'b0, 8'h12, 8'h34, 16'h03A8, 0);
    run_op("s_ffxff", 1'b1, 8'hFF, 8'hFF, 16'h0001, 0);
    run_op("s_7fx7f", 1'b1, 8'h7F, 8'h7F, 16'h3F01, 0);
    run_op("u_3x4_restart", 1'b0, 8'd3, 8'd4, 16'd12, 4);

    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (done) ndone++;
    end
    check("restart/extra_done", ndone, 0);
    check("restart/product", product, 12);

    // Reset in the middle of 7*7 aborts it.
    signed_mode = 1'b0;
    a           = 8'd7;
    b           = 8'd7;
    start       = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("abort/product", product, 0);
    check("abort/busy", busy, 0);
    check("abort/done", done, 0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort/no_done", ndone, 0);
    last_product = '0;
    run_op("u_7x7_after_rst", 1'b0, 8'd7, 8'd7, 16'd49, 0);

    // start held high: 5*6 then 7*6, period W+4.
    first_edge  = -1;
    second_edge = -1;
    signed_mode = 1'b0;
    a           = 8'd5;
    b           = 8'd6;
    start       = 1'b1;
    tick();
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done && first_edge < 0) begin
        first_edge = i;
        check("b2b/first_product", product, 30);
        a = 8'd7;
      end else if (done) begin
        second_edge = i;
        start = 1'b0;
        break;
      end
    end
    check("b2b/first_latency", first_edge, W + 2);
    check("b2b/period", second_edge - first_edge, W + 4);
    check("b2b/second_product", product, 42);
    start = 1'b0;
    tick();
    check("b2b/idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
